nco_sweep_ctrl: RTL
===================

Name: nco_sweep_ctrl

Overview:
- Frequency-sweep controller directly upstream of the NCO; drives its freq_res (phase increment) and phase inputs.
- Steps freq_res linearly from a start value to a stop value, holding each step for a programmable number of clocks.
- Supports single-shot and continuous (sawtooth) sweeps, up or down, plus a start-phase load.
- Lets the synthesizer generate chirps without a processor writing every step.

Parameters:
FREQ_W, 6, width of frequency increment (matches NCO freq_res)
PHASE_W, 8, width of phase word (matches NCO phase)
DWELL_W, 16, width of dwell counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin sweep (sampled only in IDLE)
stop  input  1  abort sweep
mode  input  1  0 = single-shot, 1 = continuous
f_start  input  FREQ_W  first increment of sweep
f_stop  input  FREQ_W  last increment of sweep
f_step  input  FREQ_W  increment change per step (0 treated as 1)
dwell  input  DWELL_W  hold length per step = dwell+1 clocks
phase_init  input  PHASE_W  phase word issued at sweep start
freq_res  output  FREQ_W  increment to NCO
phase  output  PHASE_W  phase word to NCO
busy  output  1  high while sweeping
done  output  1  one-clock pulse at single-shot completion

Behaviour:
- Reset values: freq_res = 1, phase = 0, busy = 0, done = 0, state = IDLE, dwell counter = 0. freq_res = 1 matches the NCO's own reset increment.
- States: IDLE, DWELL, FINISH.
- IDLE, start=1 and stop=0 at edge T:
  - Latch f_start, f_stop, f_step (0 becomes 1), dwell, mode.
  - Direction = up if f_stop >= f_start, else down.
  - After edge T: freq_res = f_start, phase = phase_init, busy = 1, counter = 0, go to DWELL.
- IDLE, start=0: all outputs hold. freq_res keeps its last value. done is 0 except the single pulse cycle.
- DWELL:
  - Counter increments each clock.
  - When counter == latched dwell, counter clears and the next value is computed in FREQ_W+1 bits (no wrap).
  - Up: nxt = freq_res + step. Down: nxt = freq_res - step, signed compare.
  - If freq_res already equals f_stop, the end of the final dwell has been reached:
    - mode 0: go to FINISH.
    - mode 1: freq_res = f_start, stay in DWELL (sawtooth restart).
  - Else if nxt overshoots or reaches f_stop (up: nxt >= f_stop; down: nxt <= f_stop): freq_res = f_stop.
  - Else: freq_res = nxt[FREQ_W-1:0].
  - Net effect: every value, including f_start and f_stop, is held exactly dwell+1 clocks.
- FINISH: one clock with done = 1, busy = 0; then IDLE. freq_res stays at f_stop.
- phase changes only at sweep start and is constant otherwise; phase is never touched on the continuous restart.
- stop=1 in DWELL or FINISH: next state IDLE, busy = 0, done = 0 (no pulse), freq_res and phase hold their current values.
- start and stop both high in IDLE: stop wins, no sweep starts.
- start while busy is ignored; latched parameters cannot change mid-sweep.
- f_start == f_stop: a single dwell of dwell+1 clocks, then FINISH (or repeat in mode 1).
- rst mid-sweep: immediate return to reset values on that edge.
- Latency: start to freq_res valid = 1 clock. Downstream NCO applies the new phase 3 clocks after the change.

Test Plan:
- Reset check: assert rst for 2 clocks, inputs arbitrary -> freq_res = 1, phase = 0, busy = 0, done = 0.
- Single up sweep: f_start=4, f_stop=10, f_step=3, dwell=2, mode=0, phase_init=0x40, start pulse -> phase = 0x40 and freq_res runs 4,4,4,7,7,7,10,10,10. Then done = 1 for one clock, busy falls with it, freq_res stays 10.
- Down sweep with clamp: f_start=20, f_stop=3, f_step=8, dwell=0 -> freq_res 20,12,4,3 (one clock each), then done pulse.
- Top-of-range, no wrap: f_start=60, f_stop=63, f_step=5, dwell=1 -> 60,60,63,63, done; freq_res never shows a wrapped value such as 1.
- Continuous mode: f_start=1, f_stop=3, f_step=0 (treated as 1), dwell=0, mode=1 -> 1,2,3,1,2,3,... with done never asserted. stop at an arbitrary cycle -> busy = 0 next clock, freq_res frozen, no done pulse.
- Interference: start pulsed mid-sweep -> ignored, sequence unchanged. start and stop together in IDLE -> busy stays 0. rst during DWELL -> reset values on the next edge.

Source files
------------

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep controller feeding the NCO freq_res/phase inputs (linear chirp generator).
// Latency: start to first freq_res value = 1 clock; each step held dwell+1 clocks.
// Backpressure: none; stop aborts immediately, start is ignored while a sweep is running.
module nco_sweep_ctrl #(
    parameter int FREQ_W  = 6,
    parameter int PHASE_W = 8,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [FREQ_W-1:0]  f_start,
    input  logic [FREQ_W-1:0]  f_stop,
    input  logic [FREQ_W-1:0]  f_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [PHASE_W-1:0] phase_init,
    output logic [FREQ_W-1:0]  freq_res,
    output logic [PHASE_W-1:0] phase,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DWELL  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [FREQ_W-1:0]    freq_res_q, freq_res_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;

    // Sweep parameters captured at start so input changes mid-sweep have no effect.
    logic [FREQ_W-1:0]    fstart_q, fstart_d;
    logic [FREQ_W-1:0]    fstop_q, fstop_d;
    logic [FREQ_W-1:0]    fstep_q, fstep_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 mode_q, mode_d;
    logic                 up_q, up_d;

    // One extra bit so the next step can be compared against f_stop without wrapping.
    logic [FREQ_W:0]      nxt_up;
    logic [FREQ_W:0]      nxt_dn;
    logic                 hit_up;
    logic                 hit_dn;

    // Candidate next increment and whether it reaches or passes the end point.
    always_comb begin
        nxt_up = {1'b0, freq_res_q} + {1'b0, fstep_q};
        nxt_dn = {1'b0, freq_res_q} - {1'b0, fstep_q};
        hit_up = (nxt_up >= {1'b0, fstop_q});
        hit_dn = ($signed(nxt_dn) <= $signed({1'b0, fstop_q}));
    end

    // Next-state and output computation for the sweep FSM.
    always_comb begin
        state_d    = state_q;
        freq_res_d = freq_res_q;
        phase_d    = phase_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        fstart_d   = fstart_q;
        fstop_d    = fstop_q;
        fstep_d    = fstep_q;
        dwell_d    = dwell_q;
        mode_d     = mode_q;
        up_d       = up_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                // stop wins over a simultaneous start
                if (start && !stop) begin
                    fstart_d   = f_start;
                    fstop_d    = f_stop;
                    fstep_d    = (f_step == '0) ? FREQ_W'(1) : f_step;
                    dwell_d    = dwell;
                    mode_d     = mode;
                    up_d       = (f_stop >= f_start);
                    freq_res_d = f_start;
                    phase_d    = phase_init;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (stop) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == dwell_q) begin
                    cnt_d = '0;
                    if (freq_res_q == fstop_q) begin
                        // End of the final dwell: restart sawtooth or finish.
                        if (mode_q) begin
                            freq_res_d = fstart_q;
                        end else begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_FINISH;
                        end
                    end else if (up_q ? hit_up : hit_dn) begin
                        freq_res_d = fstop_q;
                    end else begin
                        freq_res_d = up_q ? nxt_up[FREQ_W-1:0] : nxt_dn[FREQ_W-1:0];
                    end
                end else begin
                    cnt_d = cnt_q + {{(DWELL_W-1){1'b0}}, 1'b1};
                end
            end
            ST_FINISH: begin
                // done pulse lasts exactly this one cycle; stop here also lands in IDLE
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            freq_res_q <= FREQ_W'(1);
            phase_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            fstart_q   <= '0;
            fstop_q    <= '0;
            fstep_q    <= FREQ_W'(1);
            dwell_q    <= '0;
            mode_q     <= 1'b0;
            up_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            freq_res_q <= freq_res_d;
            phase_q    <= phase_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            fstart_q   <= fstart_d;
            fstop_q    <= fstop_d;
            fstep_q    <= fstep_d;
            dwell_q    <= dwell_d;
            mode_q     <= mode_d;
            up_q       <= up_d;
        end
    end

    assign freq_res = freq_res_q;
    assign phase    = phase_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
